// File: rtl/i2c_target.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2c_target : I2C target exposing four 8-bit registers with auto-inc ptr    |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h42
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic [31:0] regs_o,
  output logic        wr_stb,
  output logic [1:0]  wr_idx,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RACK      = 4'd8,
    IGNORE    = 4'd9
  } state_t;

  // [1:0] synchronize, [2] holds the previous synchronized level for edges
  logic [2:0] scl_sr, sda_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sr <= 3'b111;
      sda_sr <= 3'b111;
    end else begin
      scl_sr <= {scl_sr[1:0], scl_i};
      sda_sr <= {sda_sr[1:0], sda_i};
    end
  end

  logic scl, sda, scl_rise, scl_fall, start_det, stop_det;
  assign scl       = scl_sr[1];
  assign sda       = sda_sr[1];
  assign scl_rise  = scl & ~scl_sr[2];
  assign scl_fall  = ~scl & scl_sr[2];
  assign start_det = scl & scl_sr[2] & ~sda & sda_sr[2];
  assign stop_det  = scl & scl_sr[2] & sda & ~sda_sr[2];

  state_t          state, state_n;
  logic [3:0]      bit_cnt, bit_cnt_n;
  logic [7:0]      shreg, shreg_n;
  logic [1:0]      ptr, ptr_n, ptr_inc;
  logic            rw, rw_n, mack, mack_n;
  logic            sda_oe_n, busy_n, wr_stb_n;
  logic [1:0]      wr_idx_n;
  logic [3:0][7:0] regs, regs_n;

  assign ptr_inc = ptr + 2'd1;
  assign regs_o  = regs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      shreg   <= 8'h00;
      ptr     <= 2'd0;
      rw      <= 1'b0;
      mack    <= 1'b1;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_idx  <= 2'd0;
      regs    <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      ptr     <= ptr_n;
      rw      <= rw_n;
      mack    <= mack_n;
      sda_oe  <= sda_oe_n;
      busy    <= busy_n;
      wr_stb  <= wr_stb_n;
      wr_idx  <= wr_idx_n;
      regs    <= regs_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    rw_n      = rw;
    mack_n    = mack;
    sda_oe_n  = sda_oe;
    busy_n    = busy;
    wr_stb_n  = 1'b0;
    wr_idx_n  = wr_idx;
    regs_n    = regs;

    if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = 4'd0;
      sda_oe_n  = 1'b0;
    end else if (stop_det) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shreg_n   = {shreg[6:0], sda};
            bit_cnt_n = bit_cnt + 4'd1;
            // Data byte commits on its 8th rising edge, so an abort never writes
            if (state == WDATA && bit_cnt == 4'd7) begin
              regs_n[ptr] = {shreg[6:0], sda};
              wr_stb_n    = 1'b1;
              wr_idx_n    = ptr;
              ptr_n       = ptr_inc;
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (state == ADDR) begin
              if (shreg[7:1] == DEV_ADDR) begin
                state_n  = ADDR_ACK;
                sda_oe_n = 1'b1;
                busy_n   = 1'b1;
                rw_n     = shreg[0];
              end else begin
                state_n = IGNORE;
                busy_n  = 1'b0;
              end
            end else if (state == PTR) begin
              state_n  = PTR_ACK;
              ptr_n    = shreg[1:0];
              sda_oe_n = 1'b1;
            end else begin
              state_n  = WDATA_ACK;
              sda_oe_n = 1'b1;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_n = 4'd0;
            if (rw) begin
              state_n  = RDATA;
              shreg_n  = regs[ptr];
              sda_oe_n = ~regs[ptr][7];
            end else begin
              state_n  = PTR;
              sda_oe_n = 1'b0;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            state_n   = WDATA;
            bit_cnt_n = 4'd0;
            sda_oe_n  = 1'b0;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_n  = RACK;
              sda_oe_n = 1'b0;
            end else begin
              shreg_n  = {shreg[6:0], 1'b0};
              sda_oe_n = ~shreg[6];
            end
          end
        end
        RACK: begin
          if (scl_rise) begin
            mack_n = sda;
          end else if (scl_fall) begin
            bit_cnt_n = 4'd0;
            if (!mack) begin
              state_n  = RDATA;
              ptr_n    = ptr_inc;
              shreg_n  = regs[ptr_inc];
              sda_oe_n = ~regs[ptr_inc][7];
            end else begin
              state_n  = IGNORE;
              sda_oe_n = 1'b0;
            end
          end
        end
        default: begin
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_i2c_target : bus-master bench with write-strobe scoreboard              |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_i2c_target;

  localparam time Q = 50ns;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_oe;
  logic [31:0] regs_o;
  logic        wr_stb;
  logic [1:0]  wr_idx;
  logic        busy;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target #(.DEV_ADDR(7'h42)) dut (
    .clk    (clk),
    .rst    (rst),
    .scl_i  (scl),
    .sda_i  (sda_line),
    .sda_oe (sda_oe),
    .regs_o (regs_o),
    .wr_stb (wr_stb),
    .wr_idx (wr_idx),
    .busy   (busy)
  );

  always #5ns clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] idx;
    logic [7:0] data;
  } wr_t;
  wr_t sb[$];
  wr_t exp_wr;
  logic oe_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [1:0] idx, input logic [7:0] data);
    wr_t e;
    e.idx  = idx;
    e.data = data;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every register-write strobe must match the next expectation
  always @(negedge clk) begin
    if (!rst && wr_stb) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wr_stb actual_idx=%0d data=%h required=none", wr_idx, regs_o[8*wr_idx +: 8]);
      end else begin
        exp_wr = sb.pop_front();
        check("wr_idx", {30'd0, wr_idx}, {30'd0, exp_wr.idx});
        check("wr_data", {24'd0, regs_o[8*wr_idx +: 8]}, {24'd0, exp_wr.data});
      end
    end
  end

  always @(posedge clk) if (sda_oe) oe_seen <= 1'b1;

  task automatic bus_start();
    sda_m = 1'b1; #Q;
    scl   = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q;
    scl   = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic clk_bit(input logic b, output logic got);
    sda_m = b;    #Q;
    scl   = 1'b1; #Q;
    got   = sda_line; #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic g;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], g);
    clk_bit(1'b1, g);
    ack = ~g;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic g;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, g);
      d[i] = g;
    end
    clk_bit(~master_ack, g);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  logic       ack;
  logic [7:0] rd;
  logic       g;

  initial begin
    repeat (5) @(posedge clk);
    #1;
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_regs", regs_o, 32'h0);
    check("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
    check("rst_wr_idx", {30'd0, wr_idx}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #(4*Q);

    // Write 0xA5, 0x3C starting at register 1
    expect_wr(2'd1, 8'hA5);
    expect_wr(2'd2, 8'h3C);
    bus_start();
    write_byte(8'h84, ack); check("w1_addr_ack", {31'd0, ack}, 32'd1);
    check("w1_busy", {31'd0, busy}, 32'd1);
    write_byte(8'h01, ack); check("w1_ptr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'hA5, ack); check("w1_d0_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h3C, ack); check("w1_d1_ack", {31'd0, ack}, 32'd1);
    bus_stop();
    #Q;
    check("w1_regs", regs_o, 32'h003C_A500);
    check("w1_busy_after_stop", {31'd0, busy}, 32'd0);

    // Set pointer 2, repeated START, read two bytes
    bus_start();
    write_byte(8'h84, ack); check("r_addr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h02, ack); check("r_ptr_ack", {31'd0, ack}, 32'd1);
    bus_start();
    write_byte(8'h85, ack); check("r_addr_rd_ack", {31'd0, ack}, 32'd1);
    read_byte(1'b1, rd); check("r_byte0", {24'd0, rd}, 32'h3C);
    read_byte(1'b0, rd); check("r_byte1", {24'd0, rd}, 32'h00);
    check("r_oe_after_nack", {31'd0, sda_oe}, 32'd0);
    bus_stop();
    #Q;
    check("r_busy_after_stop", {31'd0, busy}, 32'd0);

    // Address 0x43 must be ignored entirely
    oe_seen = 1'b0;
    bus_start();
    write_byte(8'h86, ack); check("nm_addr_nack", {31'd0, ack}, 32'd0);
    check("nm_busy", {31'd0, busy}, 32'd0);
    write_byte(8'hFF, ack);
    bus_stop();
    #Q;
    check("nm_oe_never", {31'd0, oe_seen}, 32'd0);
    check("nm_regs", regs_o, 32'h003C_A500);

    // Pointer wrap 3 -> 0
    expect_wr(2'd3, 8'h11);
    expect_wr(2'd0, 8'h22);
    bus_start();
    write_byte(8'h84, ack);
    write_byte(8'h03, ack);
    write_byte(8'h11, ack); check("wrap_d0_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h22, ack); check("wrap_d1_ack", {31'd0, ack}, 32'd1);
    bus_stop();
    #Q;
    check("wrap_regs", regs_o, 32'h113C_A522);

    // STOP after 4 data bits aborts the byte
    bus_start();
    write_byte(8'h84, ack);
    write_byte(8'h01, ack);
    clk_bit(1'b1, g); clk_bit(1'b0, g); clk_bit(1'b1, g); clk_bit(1'b0, g);
    bus_stop();
    #Q;
    check("abort_regs", regs_o, 32'h113C_A522);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_oe", {31'd0, sda_oe}, 32'd0);

    // Reset while the address ACK is being driven
    bus_start();
    for (int i = 7; i >= 0; i--) clk_bit(logic'((8'h84 >> i) & 8'h01), g);
    sda_m = 1'b1; #Q;
    check("ack_driven", {31'd0, sda_oe}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_mid_regs", regs_o, 32'h0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_idx", {30'd0, wr_idx}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #Q;
    bus_stop();
    #(2*Q);
    expect_wr(2'd0, 8'h5A);
    bus_start();
    write_byte(8'h84, ack); check("post_rst_addr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h00, ack);
    write_byte(8'h5A, ack); check("post_rst_d_ack", {31'd0, ack}, 32'd1);
    bus_stop();
    #Q;
    check("post_rst_regs", regs_o, 32'h0000_005A);

    check("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
